led_bcd_feeder: RTL and testbench
=================================

LED_BCD_FEEDER -- requirements
Module: led_bcd_feeder

Interface
REQ-001 Parameter: BLANK_LZ, default 1, meaning 1 = blank leading zeros and 0 = show all eight digits.
REQ-002 Port: clk  input  1  system clock (50 MHz); every register updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 Port: in_valid  input  1  in_data holds a value to display.
REQ-005 Port: in_ready  output  1  block can accept a value.
REQ-006 Port: in_data  input  27  unsigned binary value.
REQ-007 Port: cs_pointer  input  3  digit currently scanned by the downstream scanner; 0 = rightmost digit.
REQ-008 Port: dig_ctrl  output  5  glyph code for the digit selected by cs_pointer, fed to the 7-segment decoder.
REQ-009 Port: upd_pulse  output  1  one-cycle strobe marking a display-register commit.

Function
REQ-010 Glyph codes SHALL be: 0x00-0x09 for digits, 0x10 for blank, 0x11 for '-', 0x1F for all segments lit.
REQ-011 The FSM SHALL have three states: IDLE, CONV and COMMIT.
REQ-012 in_ready SHALL be 1 only in IDLE.
REQ-013 A transfer SHALL occur on an edge where in_valid=1 and in_ready=1; in_valid while in_ready=0 SHALL be ignored, with no buffering.
REQ-014 On a transfer, the block SHALL:
- load in_data into a 27-bit shift register;
- clear a 32-bit BCD accumulator and the 5-bit step counter;
- capture ovf = (in_data > 99_999_999);
- enter CONV.
REQ-015 Each CONV cycle SHALL perform one double-dabble step:
- add 3 to every BCD nibble >= 5;
- then shift {BCD, binary} left by one.
REQ-016 CONV SHALL last exactly 27 cycles; after the 27th step the FSM SHALL enter COMMIT.
REQ-017 COMMIT SHALL last one cycle and then enter IDLE.
REQ-018 On the COMMIT edge the block SHALL write all eight display registers at once, so the display never shows a partially converted value.
REQ-019 upd_pulse SHALL be 1 for exactly the cycle following the COMMIT edge.
REQ-020 Latency: for a transfer at edge E0, the display SHALL update at E28, and in_ready SHALL return to 1 after E28; the next accept is possible at E29.
REQ-021 Overflow: if ovf=1, all eight display registers SHALL be written 0x11 regardless of the BCD result.
REQ-022 Leading-zero blanking (BLANK_LZ=1): every digit above the most-significant nonzero digit SHALL be written 0x10.
REQ-023 Value 0 SHALL show 0x00 on digit 0 and 0x10 on digits 1-7.
REQ-024 With BLANK_LZ=0, all eight digits SHALL be written as BCD values.
REQ-025 The maximum value 99_999_999 SHALL display as eight 0x09 digits.
REQ-026 dig_ctrl SHALL be combinational: display register [cs_pointer], with zero latency from cs_pointer.
REQ-027 The display registers SHALL hold their value indefinitely between commits.
REQ-028 A cs_pointer change during CONV SHALL read the old display contents.

Reset
REQ-029 While rst_n=0, the block SHALL force:
- FSM to IDLE and in_ready to 1;
- upd_pulse to 0;
- shift register, accumulator, counter and ovf to 0;
- all display registers to 0x1F, so dig_ctrl reads 0x1F (lamp test).
REQ-030 A reset asserted mid-CONV or in COMMIT SHALL abort the conversion with no commit and no upd_pulse.
REQ-031 After rst_n deasserts, the block SHALL accept a transfer on the first rising edge.

Verification
REQ-032 Reset then sweep cs_pointer 0-7 -> dig_ctrl = 0x1F for all digits; in_ready = 1; upd_pulse = 0.
REQ-033 Send 12_345_678 with BLANK_LZ=1:
- in_ready = 0 for 28 cycles;
- upd_pulse once at E28+;
- digits 7..0 = 1,2,3,4,5,6,7,8.
REQ-034 Send 405 with BLANK_LZ=1 -> digits 0..7 = 5,0,4,0x10,0x10,0x10,0x10,0x10.
REQ-035 Send 0 with BLANK_LZ=1 -> digit0 = 0x00, all other digits 0x10.
REQ-035 continued: send 0 with BLANK_LZ=0 -> all digits 0x00.
REQ-036 Send 100_000_000 -> all digits 0x11.
REQ-036 continued: then send 99_999_999 -> all digits 0x09.
REQ-037 Send 42 and hold in_valid=1 with new data during CONV -> second value not taken until in_ready=1; display shows 42 first.
REQ-038 Assert rst_n=0 at step 10 of CONV -> no upd_pulse; display = 0x1F; in_ready = 1 after release.

Source files
------------

// File: rtl/led_bcd_feeder.sv
// Binary-to-BCD feeder for an eight-digit 7-segment display.
// A value is accepted in IDLE and converted by serial double-dabble over
// 27 CONV cycles. All eight display registers are then written in one
// COMMIT cycle. The scanner reads glyph codes combinationally via cs_pointer.
module led_bcd_feeder #(
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [26:0] in_data,
    input  logic [2:0]  cs_pointer,
    output logic [4:0]  dig_ctrl,
    output logic        upd_pulse
);

    localparam logic [4:0]  GlyphBlank = 5'h10;
    localparam logic [4:0]  GlyphDash  = 5'h11;
    localparam logic [4:0]  GlyphAll   = 5'h1F;
    localparam logic [4:0]  LastStep   = 5'd26;
    localparam logic [26:0] MaxValue   = 27'd99_999_999;

    typedef enum logic [1:0] {StIdle, StConv, StCommit} state_t;

    state_t      state_q, state_d;
    logic [26:0] bin_q;
    logic [31:0] bcd_q;
    logic [31:0] bcd_adj;
    logic [4:0]  cnt_q;
    logic        ovf_q;
    logic [4:0]  disp_q [8];
    logic [4:0]  glyph  [8];
    logic        xfer;

    assign in_ready = (state_q == StIdle);
    assign xfer     = in_valid && in_ready;
    assign dig_ctrl = disp_q[cs_pointer];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic: 27 CONV cycles (counter 0..26), then one COMMIT
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (xfer) state_d = StConv;
            StConv:   if (cnt_q == LastStep) state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Double-dabble correction: add 3 to every BCD nibble >= 5
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Glyph selection from the finished BCD result, blanking from the top down
    always_comb begin
        logic seen_nz;
        seen_nz = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0) seen_nz = 1'b1;
            if (ovf_q)                                         glyph[i] = GlyphDash;
            else if (BLANK_LZ != 0 && !seen_nz && i != 0)      glyph[i] = GlyphBlank;
            else                                               glyph[i] = {1'b0, bcd_q[4*i +: 4]};
        end
    end

    // Conversion datapath: load on transfer, one shift step per CONV cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (xfer) begin
            bin_q <= in_data;
            bcd_q <= '0;
            cnt_q <= '0;
            ovf_q <= (in_data > MaxValue);
        end else if (state_q == StConv) begin
            bcd_q <= {bcd_adj[30:0], bin_q[26]};
            bin_q <= {bin_q[25:0], 1'b0};
            cnt_q <= cnt_q + 5'd1;
        end
    end

    // Display registers written atomically on the COMMIT edge; lamp test on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_pulse <= 1'b0;
            for (int i = 0; i < 8; i++) disp_q[i] <= GlyphAll;
        end else begin
            upd_pulse <= (state_q == StCommit);
            if (state_q == StCommit) begin
                for (int i = 0; i < 8; i++) disp_q[i] <= glyph[i];
            end
        end
    end

endmodule

// File: tb/tb_led_bcd_feeder.sv
// Directed bench for led_bcd_feeder; dut_b runs with leading-zero blanking off.
module tb_led_bcd_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [26:0] in_data;
    logic [2:0]  cs_pointer;
    logic        in_ready, in_ready_b;
    logic        upd_pulse, upd_pulse_b;
    logic [4:0]  dig_ctrl, dig_ctrl_b;

    int errors = 0;
    int checks = 0;

    logic [4:0] dig_a [8];
    logic [4:0] dig_b [8];
    logic [4:0] exp_d [8];

    always #10 clk = ~clk;

    led_bcd_feeder #(.BLANK_LZ(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .cs_pointer(cs_pointer), .dig_ctrl(dig_ctrl),
        .upd_pulse(upd_pulse)
    );

    led_bcd_feeder #(.BLANK_LZ(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .cs_pointer(cs_pointer), .dig_ctrl(dig_ctrl_b),
        .upd_pulse(upd_pulse_b)
    );

    // Sweep cs_pointer after a falling edge and capture both displays
    task automatic read_digits();
        for (int i = 0; i < 8; i++) begin
            cs_pointer = 3'(i);
            #1;
            dig_a[i] = dig_ctrl;
            dig_b[i] = dig_ctrl_b;
        end
    endtask

    // Transfer one value and wait for in_ready to return (bounded)
    task automatic send_wait(input logic [26:0] v, output int busy, output int pulses,
                             output logic pulse_at_ready);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk);
        #1 in_valid = 1'b0;
        busy = 0;
        pulses = 0;
        pulse_at_ready = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (in_ready) break;
            busy++;
            if (upd_pulse) pulses++;
        end
        pulse_at_ready = upd_pulse;
        if (upd_pulse) pulses++;
        @(negedge clk);
        if (upd_pulse) pulses++;
        read_digits();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; cs_pointer = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_held got=%b want=1", in_ready); end
        #1 rst_n = 1'b1;
        @(negedge clk);
        read_digits();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dig_a[i] !== 5'h1F) begin errors++; $display("FAIL reset_digit%0d got=%h want=1f", i, dig_a[i]); end
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", in_ready); end
        checks++; if (upd_pulse !== 1'b0) begin errors++; $display("FAIL reset_upd got=%b want=0", upd_pulse); end
    endtask

    task automatic test_main_value();
        int busy, pulses; logic par;
        send_wait(27'd12_345_678, busy, pulses, par);
        checks++; if (busy !== 28) begin errors++; $display("FAIL main_busy got=%0d want=28", busy); end
        checks++; if (par !== 1'b1) begin errors++; $display("FAIL main_upd_at_ready got=%b want=1", par); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL main_upd_count got=%0d want=1", pulses); end
        exp_d = '{5'h08, 5'h07, 5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dig_a[i] !== exp_d[i]) begin errors++; $display("FAIL main_digit%0d got=%h want=%h", i, dig_a[i], exp_d[i]); end
        end
    endtask

    task automatic test_blanking();
        int busy, pulses; logic par;
        send_wait(27'd405, busy, pulses, par);
        exp_d = '{5'h05, 5'h00, 5'h04, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dig_a[i] !== exp_d[i]) begin errors++; $display("FAIL blank405_digit%0d got=%h want=%h", i, dig_a[i], exp_d[i]); end
        end
        send_wait(27'd0, busy, pulses, par);
        exp_d = '{5'h00, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dig_a[i] !== exp_d[i]) begin errors++; $display("FAIL zero_lz1_digit%0d got=%h want=%h", i, dig_a[i], exp_d[i]); end
            checks++;
            if (dig_b[i] !== 5'h00) begin errors++; $display("FAIL zero_lz0_digit%0d got=%h want=00", i, dig_b[i]); end
        end
    endtask

    task automatic test_limits();
        int busy, pulses; logic par;
        send_wait(27'd100_000_000, busy, pulses, par);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dig_a[i] !== 5'h11) begin errors++; $display("FAIL ovf_digit%0d got=%h want=11", i, dig_a[i]); end
        end
        send_wait(27'd99_999_999, busy, pulses, par);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dig_a[i] !== 5'h09) begin errors++; $display("FAIL max_digit%0d got=%h want=09", i, dig_a[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int busy, pulses; logic par;
        @(negedge clk);
        in_valid = 1'b1; in_data = 27'd42;
        @(posedge clk);
        #1 in_data = 27'd77;
        busy = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (in_ready) break;
            busy++;
        end
        checks++; if (busy !== 28) begin errors++; $display("FAIL b2b_busy got=%0d want=28", busy); end
        read_digits();
        exp_d = '{5'h02, 5'h04, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dig_a[i] !== exp_d[i]) begin errors++; $display("FAIL b2b_first_digit%0d got=%h want=%h", i, dig_a[i], exp_d[i]); end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept got=%b want=0", in_ready); end
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(negedge clk);
        read_digits();
        exp_d = '{5'h07, 5'h07, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dig_a[i] !== exp_d[i]) begin errors++; $display("FAIL b2b_second_digit%0d got=%h want=%h", i, dig_a[i], exp_d[i]); end
        end
    endtask

    task automatic test_reset_abort();
        int pulses, busy; logic par;
        @(negedge clk);
        in_valid = 1'b1; in_data = 27'd555;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_in_reset got=%b want=1", in_ready); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (upd_pulse) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_upd got=%0d want=0", pulses); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b want=1", in_ready); end
        read_digits();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dig_a[i] !== 5'h1F) begin errors++; $display("FAIL abort_digit%0d got=%h want=1f", i, dig_a[i]); end
        end
        // Transfer on the very first edge after reset release
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 begin rst_n = 1'b1; in_valid = 1'b1; in_data = 27'd9; end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL first_edge_accept got=%b want=0", in_ready); end
        busy = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (in_ready) break;
            busy++;
        end
        par = upd_pulse;
        checks++; if (par !== 1'b1) begin errors++; $display("FAIL first_edge_upd got=%b want=1", par); end
        read_digits();
        checks++; if (dig_a[0] !== 5'h09) begin errors++; $display("FAIL first_edge_digit0 got=%h want=09", dig_a[0]); end
        checks++; if (dig_a[1] !== 5'h10) begin errors++; $display("FAIL first_edge_digit1 got=%h want=10", dig_a[1]); end
    endtask

    initial begin
        test_reset();
        test_main_value();
        test_blanking();
        test_limits();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
